// File: rtl/sub_div_ctrl_pkg.sv
// sub_div_ctrl_pkg: shared state encoding, operand width and default divide-by-zero quotient
package sub_div_ctrl_pkg;
  localparam int W = 8;
  localparam logic [W-1:0] DIV0_QUOT_DFLT = 8'hFF;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sub_div_ctrl_if.sv
// sub_div_ctrl_if: start/busy/done handshake with operands and results; master = sequencer, slave = divider
interface sub_div_ctrl_if import sub_div_ctrl_pkg::*; ();
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_zero);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_zero);
endinterface

// File: rtl/subtractor_up.sv
// subtractor_up: 8-bit magnitude subtractor; ports acc_data, rd_data in, sub_out = |acc_data - rd_data|, bi_sub = acc_data < rd_data
module subtractor_up (
  input  logic [7:0] acc_data,
  input  logic [7:0] rd_data,
  output logic [7:0] sub_out,
  output logic       bi_sub
);
  assign bi_sub  = acc_data < rd_data;
  assign sub_out = bi_sub ? rd_data - acc_data : acc_data - rd_data;
endmodule

// File: rtl/sub_div_ctrl.sv
// sub_div_ctrl: repeated-subtraction 8-bit divider; ports clk, rst (sync active-high), bus (slave: start/dividend/divisor in, busy/done/quotient/remainder/div_zero out)
module sub_div_ctrl import sub_div_ctrl_pkg::*; #(
  parameter logic [W-1:0] DIV0_QUOT = DIV0_QUOT_DFLT
) (
  input logic          clk,
  input logic          rst,
  sub_div_ctrl_if.slave bus
);
  state_t       state, state_nx;
  logic [W-1:0] q_r, r_r, d_r, sub_out;
  logic         dz_r, bi_sub;
  logic         accept, d_zero;
  subtractor_up u_sub (
    .acc_data(r_r),
    .rd_data (d_r),
    .sub_out (sub_out),
    .bi_sub  (bi_sub)
  );
  assign accept = state == IDLE && bus.start;
  assign d_zero = bus.divisor == '0;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE ? (bus.start ? (d_zero ? DONE : SUB) : IDLE)
             : state == SUB  ? (bi_sub ? DONE : SUB)
             : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r  <= '0;
      r_r  <= '0;
      d_r  <= '0;
      dz_r <= 1'b0;
    end else if (accept) begin
      d_r  <= bus.divisor;
      r_r  <= bus.dividend;
      dz_r <= d_zero;
      q_r  <= d_zero ? DIV0_QUOT : '0;
    end else if (state == SUB && !bi_sub) begin
      r_r <= sub_out;
      q_r <= q_r + 8'd1;
    end
  end
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == DONE;
  assign bus.quotient  = q_r;
  assign bus.remainder = r_r;
  assign bus.div_zero  = dz_r;
endmodule

// File: tb/tb_sub_div_ctrl.sv
// tb_sub_div_ctrl: directed vectors against a cycle-count/arithmetic model of the divider
module tb_sub_div_ctrl;
  import sub_div_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sub_div_ctrl_if bus();
  sub_div_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  int errs = 0;
  int checks = 0;
  int m_cnt = 0;
  int m_q = 0;
  int m_r = 0;
  int m_dz = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  // model: m_cnt counts cycles left until done is over; results are plain / and %
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0;
      m_q   <= 0;
      m_r   <= 0;
      m_dz  <= 0;
    end else if (m_cnt == 0) begin
      if (bus.start === 1'b1) begin
        if (bus.divisor == 0) begin
          m_q   <= int'(DIV0_QUOT_DFLT);
          m_r   <= int'(bus.dividend);
          m_dz  <= 1;
          m_cnt <= 1;
        end else begin
          m_q   <= int'(bus.dividend) / int'(bus.divisor);
          m_r   <= int'(bus.dividend) % int'(bus.divisor);
          m_dz  <= 0;
          m_cnt <= int'(bus.dividend) / int'(bus.divisor) + 2;
        end
      end
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end
  always @(negedge clk) begin
    chk("busy", 32'(bus.busy), 32'(m_cnt > 0));
    chk("done", 32'(bus.done), 32'(m_cnt == 1));
    if (m_cnt <= 1) begin
      chk("quotient", 32'(bus.quotient), m_q);
      chk("remainder", 32'(bus.remainder), m_r);
      chk("div_zero", 32'(bus.div_zero), m_dz);
    end
  end
  task automatic wait_done(inout int lat, output int q, output int r, output int dz);
    while (bus.done !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    q  = int'(bus.quotient);
    r  = int'(bus.remainder);
    dz = int'(bus.div_zero);
  endtask
  task automatic go(input int a, input int b, output int lat, output int q, output int r, output int dz);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'(a);
    bus.divisor  = 8'(b);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    wait_done(lat, q, r, dz);
  endtask
  task automatic vec(input string n, input int a, input int b, input int eq, input int er, input int edz, input int elat);
    int lat, q, r, dz;
    go(a, b, lat, q, r, dz);
    chk({n, "_lat"}, lat, elat);
    chk({n, "_q"}, q, eq);
    chk({n, "_r"}, r, er);
    chk({n, "_dz"}, dz, edz);
  endtask
  initial begin
    int lat, q, r, dz;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_q", 32'(bus.quotient), 0);
    chk("rst_r", 32'(bus.remainder), 0);
    rst = 1'b0;
    vec("200_7", 200, 7, 28, 4, 0, 30);
    vec("5_9", 5, 9, 0, 5, 0, 2);
    vec("12_12", 12, 12, 1, 0, 0, 3);
    vec("255_1", 255, 1, 255, 0, 0, 257);
    vec("77_0", 77, 0, 255, 77, 1, 1);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 6;
    wait_done(lat, q, r, dz);
    chk("ign_lat", lat, 30);
    chk("ign_q", q, 28);
    chk("ign_r", r, 4);
    vec("9_3", 9, 3, 3, 0, 0, 5);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd255;
    bus.divisor  = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (38) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_q", 32'(bus.quotient), 0);
    chk("mid_rst_r", 32'(bus.remainder), 0);
    chk("mid_rst_dz", 32'(bus.div_zero), 0);
    rst = 1'b0;
    vec("100_10", 100, 10, 10, 0, 0, 12);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
